time_entry_loader: RTL

Keypad time-entry block for the microwave controller: collects decimal digits pressed by the user into an M:SS setting, validates it, and drives the parallel-load interface (data + active-low load strobe) of the minute, tens-of-seconds (mod-6) and seconds digit counters. It then holds the run state until the counters report zero. It sits between the keypad scanner and the countdown counter chain.

---
 rtl/time_entry_if.sv | 26 ++
 rtl/time_entry_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/time_entry_if.sv
// Keypad-side and counter-load-side signals of the microwave time-entry loader.
interface time_entry_if;
   localparam int unsigned DIGIT_W = 4;

   logic               key_valid;
   logic [DIGIT_W-1:0] key_code;
   logic               start;
   logic               clear;
   logic               timer_zero;
   logic [DIGIT_W-1:0] data_min;
   logic [DIGIT_W-1:0] data_sec_tens;
   logic [DIGIT_W-1:0] data_sec_ones;
   logic               loadn;
   logic               run;
   logic               err;

   modport master (
      output key_valid, key_code, start, clear, timer_zero,
      input  data_min, data_sec_tens, data_sec_ones, loadn, run, err
   );

   modport slave (
      input  key_valid, key_code, start, clear, timer_zero,
      output data_min, data_sec_tens, data_sec_ones, loadn, run, err
   );
endinterface

// File: rtl/time_entry_loader.sv
// Collects keypad digits into M:SS, validates on start, pulses loadn, holds run until zero.
// Optional feature macro QUICKSTART_EN: start with no digits loads 0:30 instead of erroring.
module time_entry_loader (
   input  logic          clk,
   input  logic          rst,
   time_entry_if.slave   bus
);
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned CNT_W   = 2;

   typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

   state_t             state, state_n;
   logic               key_q;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [DIGIT_W-1:0] min_n, tens_n, ones_n;
   logic               err_n;

   logic key_edge_c;
   logic accept_c;
   logic time_ok_c;
   logic quick_c;

   assign key_edge_c = bus.key_valid && !key_q && (bus.key_code <= DIGIT_W'(9));
   assign accept_c   = key_edge_c && (cnt != CNT_W'(3));
   assign time_ok_c  = (bus.data_sec_tens <= DIGIT_W'(5)) &&
                       ({bus.data_min, bus.data_sec_tens, bus.data_sec_ones} != 12'd0);

`ifdef QUICKSTART_EN
   assign quick_c = (cnt == CNT_W'(0));
`else
   assign quick_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic; priority clear > start > key
   always_comb begin
      state_n = state;
      if (bus.clear) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (time_ok_c || quick_c) state_n = LOAD;
               end else if (accept_c) begin
                  state_n = ENTRY;
               end
            end
            ENTRY:   if (bus.start && time_ok_c) state_n = LOAD;
            LOAD:    state_n = RUN;
            RUN:     if (bus.timer_zero) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Digit shift register, digit count and error pulse next values
   always_comb begin
      min_n  = bus.data_min;
      tens_n = bus.data_sec_tens;
      ones_n = bus.data_sec_ones;
      cnt_n  = cnt;
      err_n  = 1'b0;
      if (bus.clear) begin
         min_n  = '0;
         tens_n = '0;
         ones_n = '0;
         cnt_n  = '0;
      end else begin
         case (state)
            IDLE, ENTRY: begin
               if (bus.start) begin
                  if (!time_ok_c) begin
                     if (state == IDLE && quick_c) begin
                        min_n  = DIGIT_W'(0);
                        tens_n = DIGIT_W'(3);
                        ones_n = DIGIT_W'(0);
                     end else begin
                        err_n = 1'b1;
                     end
                  end
               end else if (accept_c) begin
                  min_n  = bus.data_sec_tens;
                  tens_n = bus.data_sec_ones;
                  ones_n = bus.key_code;
                  cnt_n  = cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (bus.timer_zero) begin
                  min_n  = '0;
                  tens_n = '0;
                  ones_n = '0;
                  cnt_n  = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs; loadn and run follow the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q             <= 1'b0;
         cnt               <= '0;
         bus.data_min      <= '0;
         bus.data_sec_tens <= '0;
         bus.data_sec_ones <= '0;
         bus.loadn         <= 1'b1;
         bus.run           <= 1'b0;
         bus.err           <= 1'b0;
      end else begin
         key_q             <= bus.key_valid;
         cnt               <= cnt_n;
         bus.data_min      <= min_n;
         bus.data_sec_tens <= tens_n;
         bus.data_sec_ones <= ones_n;
         bus.loadn         <= (state_n != LOAD);
         bus.run           <= (state_n == RUN);
         bus.err           <= err_n;
      end
   end
endmodule
